// File: rtl/wb_stage.sv
// wb_stage: writeback stage feeding the register file's single write port.
// Merges single-cycle EXU results with in-order, variable-latency LSU load
// responses. Tracks the rd of each outstanding load so decode can see RAW
// hazards, and stalls EXU writes that would overtake an older load (WAW).
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   exu_valid/exu_ready         EXU result handshake (ready is combinational)
//   exu_wen/exu_rd/exu_wdata    EXU result payload
//   ld_issue_valid/_ready/_rd   load dispatch; pushes rd into the pending FIFO
//   lsu_resp_valid/_data        load data, in issue order, no back-pressure
//   raddr1/2, hazard1/2         decode read ports and their hazard flags
//   rf_wen/rf_waddr/rf_wdata    registered register-file write
//   commit_valid                registered one-cycle retire pulse
//   pending_cnt                 number of outstanding loads
//   resp_err                    sticky: response arrived with nothing pending
module wb_stage #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_LOADS  = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               exu_valid,
  output logic                               exu_ready,
  input  logic                               exu_wen,
  input  logic [ADDR_WIDTH-1:0]              exu_rd,
  input  logic [DATA_WIDTH-1:0]              exu_wdata,
  input  logic                               ld_issue_valid,
  output logic                               ld_issue_ready,
  input  logic [ADDR_WIDTH-1:0]              ld_issue_rd,
  input  logic                               lsu_resp_valid,
  input  logic [DATA_WIDTH-1:0]              lsu_resp_data,
  input  logic [ADDR_WIDTH-1:0]              raddr1,
  input  logic [ADDR_WIDTH-1:0]              raddr2,
  output logic                               hazard1,
  output logic                               hazard2,
  output logic                               rf_wen,
  output logic [ADDR_WIDTH-1:0]              rf_waddr,
  output logic [DATA_WIDTH-1:0]              rf_wdata,
  output logic                               commit_valid,
  output logic [$clog2(MAX_LOADS+1)-1:0]     pending_cnt,
  output logic                               resp_err
);

  localparam int unsigned PTR_W = (MAX_LOADS > 1) ? $clog2(MAX_LOADS) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_LOADS + 1);

  // Pending-load FIFO state
  logic [ADDR_WIDTH-1:0] rd_q [MAX_LOADS];
  logic [ADDR_WIDTH-1:0] rd_d [MAX_LOADS];
  logic [MAX_LOADS-1:0]  vld_q, vld_d;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // Registered writeback and status
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  commit_q, commit_d;
  logic                  err_q, err_d;

  logic exu_hit, rd1_hit, rd2_hit;
  logic issue_acc, resp_pop, exu_acc;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_LOADS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Associative match of addresses against valid pending entries
  always_comb begin
    exu_hit = 1'b0;
    rd1_hit = 1'b0;
    rd2_hit = 1'b0;
    for (int i = 0; i < int'(MAX_LOADS); i++) begin
      if (vld_q[i]) begin
        if (rd_q[i] == exu_rd) exu_hit = 1'b1;
        if (rd_q[i] == raddr1) rd1_hit = 1'b1;
        if (rd_q[i] == raddr2) rd2_hit = 1'b1;
      end
    end
  end

  // Handshakes; exu_ready deliberately does not look at exu_valid
  always_comb begin
    ld_issue_ready = (cnt_q < CNT_W'(MAX_LOADS));
    exu_ready      = !lsu_resp_valid && !(exu_wen && (exu_rd != '0) && exu_hit);
    issue_acc      = ld_issue_valid && ld_issue_ready;
    resp_pop       = lsu_resp_valid && (cnt_q != '0);
    exu_acc        = exu_valid && exu_ready;
    // Registered-but-not-yet-written value also counts as a hazard
    hazard1 = (raddr1 != '0) && (rd1_hit || (wen_q && (waddr_q == raddr1)));
    hazard2 = (raddr2 != '0) && (rd2_hit || (wen_q && (waddr_q == raddr2)));
  end

  // Next-state: FIFO push/pop, writeback arbitration (load wins), error flag
  always_comb begin
    rd_d     = rd_q;
    vld_d    = vld_q;
    head_d   = head_q;
    tail_d   = tail_q;
    cnt_d    = cnt_q;
    wen_d    = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    commit_d = 1'b0;
    err_d    = err_q;

    if (resp_pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = ptr_inc(head_q);
      wen_d         = (rd_q[head_q] != '0);
      waddr_d       = rd_q[head_q];
      wdata_d       = lsu_resp_data;
      commit_d      = 1'b1;
    end else if (exu_acc) begin
      wen_d    = exu_wen && (exu_rd != '0);
      waddr_d  = exu_rd;
      wdata_d  = exu_wdata;
      commit_d = 1'b1;
    end

    if (lsu_resp_valid && (cnt_q == '0)) err_d = 1'b1;

    // Issue is refused at full, so the tail slot never aliases the popped head
    if (issue_acc) begin
      vld_d[tail_q] = 1'b1;
      rd_d[tail_q]  = ld_issue_rd;
      tail_d        = ptr_inc(tail_q);
    end

    case ({issue_acc, resp_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(MAX_LOADS); i++) rd_q[i] <= '0;
      vld_q    <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      commit_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rd_q     <= rd_d;
      vld_q    <= vld_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      commit_q <= commit_d;
      err_q    <= err_d;
    end
  end

  assign rf_wen       = wen_q;
  assign rf_waddr     = waddr_q;
  assign rf_wdata     = wdata_q;
  assign commit_valid = commit_q;
  assign pending_cnt  = cnt_q;
  assign resp_err     = err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected retirements are queued by the
// stimulus and popped by a monitor on every commit pulse.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        exu_valid, exu_ready, exu_wen;
  logic [4:0]  exu_rd;
  logic [31:0] exu_wdata;
  logic        ld_issue_valid, ld_issue_ready;
  logic [4:0]  ld_issue_rd;
  logic        lsu_resp_valid;
  logic [31:0] lsu_resp_data;
  logic [4:0]  raddr1, raddr2;
  logic        hazard1, hazard2;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        commit_valid;
  logic [1:0]  pending_cnt;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  wb_stage #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .MAX_LOADS(2)) dut (
    .clk(clk), .rst(rst),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_wen(exu_wen),
    .exu_rd(exu_rd), .exu_wdata(exu_wdata),
    .ld_issue_valid(ld_issue_valid), .ld_issue_ready(ld_issue_ready),
    .ld_issue_rd(ld_issue_rd),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .raddr1(raddr1), .raddr2(raddr2), .hazard1(hazard1), .hazard2(hazard2),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .commit_valid(commit_valid), .pending_cnt(pending_cnt), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    exu_valid = 1'b0; exu_wen = 1'b0; exu_rd = '0; exu_wdata = '0;
    ld_issue_valid = 1'b0; ld_issue_rd = '0;
    lsu_resp_valid = 1'b0; lsu_resp_data = '0;
    raddr1 = '0; raddr2 = '0;
  endtask

  task automatic push(input logic wen, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.wen = wen; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every commit pulse must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (commit_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL commit: unexpected retire wen=%0b addr=%0d data=0x%0h",
                 rf_wen, rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        if ((rf_wen !== e.wen) ||
            (e.wen && ((rf_waddr !== e.addr) || (rf_wdata !== e.data)))) begin
          errors++;
          $display("FAIL commit: got wen=%0b addr=%0d data=0x%0h, expected wen=%0b addr=%0d data=0x%0h",
                   rf_wen, rf_waddr, rf_wdata, e.wen, e.addr, e.data);
        end
      end
    end else if (rf_wen === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wen_no_commit: rf_wen=1 addr=%0d with commit_valid=0, expected no write", rf_waddr);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_rf_wen",    32'(rf_wen), 32'd0);
    chk("rst_rf_waddr",  32'(rf_waddr), 32'd0);
    chk("rst_rf_wdata",  rf_wdata, 32'd0);
    chk("rst_commit",    32'(commit_valid), 32'd0);
    chk("rst_pending",   32'(pending_cnt), 32'd0);
    chk("rst_resp_err",  32'(resp_err), 32'd0);
    chk("rst_ld_ready",  32'(ld_issue_ready), 32'd1);
    chk("rst_exu_ready", 32'(exu_ready), 32'd1);

    // EXU write, then RAW hazard on the registered write for one cycle
    exu_valid = 1'b1; exu_wen = 1'b1; exu_rd = 5'd5; exu_wdata = 32'h1234;
    push(1'b1, 5'd5, 32'h1234);
    #1 chk("s1_exu_ready", 32'(exu_ready), 32'd1);
    tick();
    idle(); raddr1 = 5'd5;
    #1;
    chk("s1_rf_wen",   32'(rf_wen), 32'd1);
    chk("s1_rf_waddr", 32'(rf_waddr), 32'd5);
    chk("s1_rf_wdata", rf_wdata, 32'h1234);
    chk("s1_commit",   32'(commit_valid), 32'd1);
    chk("s1_hazard1",  32'(hazard1), 32'd1);
    tick();
    #1;
    chk("s1_hazard1_clr", 32'(hazard1), 32'd0);
    chk("s1_commit_clr",  32'(commit_valid), 32'd0);

    // Fill the FIFO, refuse issue at full even with a simultaneous pop
    idle();
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd3;
    #1 chk("s2_ld_ready0", 32'(ld_issue_ready), 32'd1);
    tick();
    ld_issue_rd = 5'd7;
    tick();
    ld_issue_valid = 1'b0; raddr1 = 5'd3; raddr2 = 5'd7;
    #1;
    chk("s2_pending_full", 32'(pending_cnt), 32'd2);
    chk("s2_ld_ready_full", 32'(ld_issue_ready), 32'd0);
    chk("s2_hazard1", 32'(hazard1), 32'd1);
    chk("s2_hazard2", 32'(hazard2), 32'd1);
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd9;
    lsu_resp_valid = 1'b1; lsu_resp_data = 32'hA;
    push(1'b1, 5'd3, 32'hA);
    #1;
    chk("s2_ld_ready_full_pop", 32'(ld_issue_ready), 32'd0);
    chk("s2_exu_ready_resp", 32'(exu_ready), 32'd0);
    tick();
    lsu_resp_data = 32'hB;
    push(1'b1, 5'd7, 32'hB);
    #1;
    chk("s2_pending_1a", 32'(pending_cnt), 32'd1);
    chk("s2_ld_ready1", 32'(ld_issue_ready), 32'd1);
    chk("s2_waddr3", 32'(rf_waddr), 32'd3);
    chk("s2_wdataA", rf_wdata, 32'hA);
    tick();
    ld_issue_valid = 1'b0; lsu_resp_data = 32'hC;
    push(1'b1, 5'd9, 32'hC);
    #1;
    chk("s2_pending_1b", 32'(pending_cnt), 32'd1);
    chk("s2_waddr7", 32'(rf_waddr), 32'd7);
    tick();
    lsu_resp_valid = 1'b0; raddr1 = 5'd7; raddr2 = 5'd9;
    #1;
    chk("s2_pending_0", 32'(pending_cnt), 32'd0);
    chk("s2_waddr9", 32'(rf_waddr), 32'd9);
    chk("s2_wdataC", rf_wdata, 32'hC);
    chk("s2_hazard2_reg", 32'(hazard2), 32'd1);
    chk("s2_hazard1_none", 32'(hazard1), 32'd0);
    tick();
    #1 chk("s2_hazard2_clr", 32'(hazard2), 32'd0);

    // WAW stall behind a pending load to the same rd
    idle();
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd4;
    tick();
    ld_issue_valid = 1'b0;
    exu_valid = 1'b1; exu_wen = 1'b1; exu_rd = 5'd4; exu_wdata = 32'h44;
    #1 chk("s3_waw_stall", 32'(exu_ready), 32'd0);
    exu_wen = 1'b0;
    #1 chk("s3_nowen_ok", 32'(exu_ready), 32'd1);
    exu_wen = 1'b1;
    #1;
    tick();
    #1;
    chk("s3_waw_stall2", 32'(exu_ready), 32'd0);
    chk("s3_no_commit", 32'(commit_valid), 32'd0);
    lsu_resp_valid = 1'b1; lsu_resp_data = 32'h40;
    push(1'b1, 5'd4, 32'h40);
    push(1'b1, 5'd4, 32'h44);
    #1 chk("s3_resp_stall", 32'(exu_ready), 32'd0);
    tick();
    lsu_resp_valid = 1'b0;
    #1;
    chk("s3_exu_ready", 32'(exu_ready), 32'd1);
    chk("s3_load_first", rf_wdata, 32'h40);
    tick();
    exu_valid = 1'b0;
    #1;
    chk("s3_exu_second", rf_wdata, 32'h44);
    chk("s3_exu_waddr", 32'(rf_waddr), 32'd4);

    // Simultaneous load response and EXU result: load wins
    idle();
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd2;
    tick();
    ld_issue_valid = 1'b0;
    lsu_resp_valid = 1'b1; lsu_resp_data = 32'h22;
    exu_valid = 1'b1; exu_wen = 1'b1; exu_rd = 5'd9; exu_wdata = 32'h99;
    push(1'b1, 5'd2, 32'h22);
    push(1'b1, 5'd9, 32'h99);
    #1 chk("s4_exu_blocked", 32'(exu_ready), 32'd0);
    tick();
    lsu_resp_valid = 1'b0;
    #1;
    chk("s4_load_waddr", 32'(rf_waddr), 32'd2);
    chk("s4_exu_ready", 32'(exu_ready), 32'd1);
    tick();
    exu_valid = 1'b0;
    #1;
    chk("s4_exu_waddr", 32'(rf_waddr), 32'd9);
    chk("s4_exu_wdata", rf_wdata, 32'h99);

    // x0 destinations retire without writing; empty-FIFO response errors
    idle();
    exu_valid = 1'b1; exu_wen = 1'b1; exu_rd = 5'd0; exu_wdata = 32'h55;
    push(1'b0, 5'd0, 32'h0);
    tick();
    exu_valid = 1'b0;
    #1;
    chk("s5_x0_wen", 32'(rf_wen), 32'd0);
    chk("s5_x0_commit", 32'(commit_valid), 32'd1);
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd0;
    tick();
    ld_issue_valid = 1'b0;
    lsu_resp_valid = 1'b1; lsu_resp_data = 32'h66;
    push(1'b0, 5'd0, 32'h0);
    tick();
    lsu_resp_valid = 1'b0;
    #1;
    chk("s5_ldx0_wen", 32'(rf_wen), 32'd0);
    chk("s5_ldx0_commit", 32'(commit_valid), 32'd1);
    chk("s5_ldx0_pending", 32'(pending_cnt), 32'd0);
    chk("s5_err_before", 32'(resp_err), 32'd0);
    lsu_resp_valid = 1'b1; lsu_resp_data = 32'hDEAD;
    tick();
    lsu_resp_valid = 1'b0;
    #1;
    chk("s5_err_set", 32'(resp_err), 32'd1);
    chk("s5_err_no_commit", 32'(commit_valid), 32'd0);
    chk("s5_err_no_wen", 32'(rf_wen), 32'd0);
    tick(); tick();
    #1 chk("s5_err_sticky", 32'(resp_err), 32'd1);

    // Reset with loads in flight and a simultaneous EXU offer
    idle();
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd10;
    tick();
    ld_issue_rd = 5'd11;
    tick();
    ld_issue_valid = 1'b0;
    #1 chk("s6_pending2", 32'(pending_cnt), 32'd2);
    rst = 1'b1;
    exu_valid = 1'b1; exu_wen = 1'b1; exu_rd = 5'd12; exu_wdata = 32'h12;
    tick();
    rst = 1'b0; exu_valid = 1'b0; raddr1 = 5'd10;
    #1;
    chk("s6_rf_wen", 32'(rf_wen), 32'd0);
    chk("s6_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("s6_rf_wdata", rf_wdata, 32'd0);
    chk("s6_commit", 32'(commit_valid), 32'd0);
    chk("s6_pending", 32'(pending_cnt), 32'd0);
    chk("s6_resp_err", 32'(resp_err), 32'd0);
    chk("s6_hazard1", 32'(hazard1), 32'd0);
    chk("s6_ld_ready", 32'(ld_issue_ready), 32'd1);
    lsu_resp_valid = 1'b1; lsu_resp_data = 32'h77;
    tick();
    lsu_resp_valid = 1'b0;
    #1;
    chk("s6_late_err", 32'(resp_err), 32'd1);
    chk("s6_late_no_wen", 32'(rf_wen), 32'd0);
    chk("s6_late_no_commit", 32'(commit_valid), 32'd0);
    chk("s6_late_pending", 32'(pending_cnt), 32'd0);
    tick(); tick();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
